// File: rtl/sel_dec_pkg.sv
// Shared types and the command-legality rule for the select decoder.
package sel_dec_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    typedef enum logic {
        IDLE    = 1'b0,
        SCAN_ST = 1'b1
    } state_t;

    // A command is legal when its start code is in range and, for SCAN,
    // the run length lies in 1..limit. DIRECT ignores len entirely.
    function automatic logic legal_cmd(input mode_t mode, input int sel,
                                       input int len, input int limit);
        logic sel_ok;
        logic len_ok;
        sel_ok = (sel < limit);
        len_ok = (mode == DIRECT) || ((len >= 1) && (len <= limit));
        return sel_ok && len_ok;
    endfunction

endpackage

// File: rtl/sel_decoder_onehot_dec.sv
// Combinational code-to-one-hot map with an in-range flag.
// Codes at or above LIMIT decode to all-zero.
module onehot_dec #(
    parameter int SEL_W = 4,
    parameter int N_OUT = 2**SEL_W,
    parameter int LIMIT = 9
) (
    input  logic [SEL_W-1:0] code,
    output logic [N_OUT-1:0] onehot,
    output logic             in_range
);

    // One bit wider than the code so LIMIT = N_OUT is representable.
    localparam logic [SEL_W:0] LIMIT_W = (SEL_W+1)'(LIMIT);

    // Range check first, then shift only legal codes.
    always_comb begin
        in_range = ({1'b0, code} < LIMIT_W);
        if (in_range) begin
            onehot = {{(N_OUT-1){1'b0}}, 1'b1} << code;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/sel_decoder.sv
// Registered select decoder: DIRECT one-hot decode plus a SCAN mode that
// walks the one-hot through len consecutive legal codes, one per cycle.
module sel_decoder
    import sel_dec_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int N_OUT = 2**SEL_W,
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W:0]   len,
    input  logic             abort,
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    output logic             err,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LIMIT - 1);
    localparam logic [SEL_W:0]   ONE_CNT  = (SEL_W+1)'(1);

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0]   cnt;        // steps still to emit after the current one
    logic [SEL_W-1:0] next_code;
    logic [N_OUT-1:0] next_onehot;
    logic             next_in_range;
    logic             accept;
    logic             cmd_ok;

    // Ready depends only on state and abort, never on the command inputs.
    always_comb begin
        in_ready = (state == IDLE) && !abort;
        accept   = in_valid && in_ready;
    end

    // Code to decode at the next edge: the new select when idle, otherwise
    // the successor of idx. The wrap test precedes the increment so
    // LIMIT = N_OUT never overflows.
    always_comb begin
        if (state == IDLE) begin
            next_code = sel;
        end else if (idx == LAST_IDX) begin
            next_code = '0;
        end else begin
            next_code = idx + 1'b1;
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT),
        .LIMIT (LIMIT)
    ) u_dec (
        .code     (next_code),
        .onehot   (next_onehot),
        .in_range (next_in_range)
    );

    // Legality of the command presented while idle.
    always_comb begin
        cmd_ok = next_in_range &&
                 legal_cmd(mode_t'(mode), int'(sel), int'(len), LIMIT);
    end

    // FSM, scan index, step counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!cmd_ok) begin
                            out <= '0;
                            err <= 1'b1;
                        end else begin
                            out       <= next_onehot;
                            out_valid <= 1'b1;
                            idx       <= next_code;
                            if (mode_t'(mode) == DIRECT) begin
                                done <= 1'b1;
                            end else begin
                                cnt   <= len - ONE_CNT;
                                done  <= (len == ONE_CNT);
                                state <= SCAN_ST;
                            end
                        end
                    end
                end
                SCAN_ST: begin
                    if (cnt == '0) begin
                        // Final step was shown last cycle; out keeps it.
                        state <= IDLE;
                    end else begin
                        out       <= next_onehot;
                        out_valid <= 1'b1;
                        idx       <= next_code;
                        cnt       <= cnt - ONE_CNT;
                        done      <= (cnt == ONE_CNT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sel_decoder.md
# sel_decoder

Parametrised, registered select decoder: the next generation of the register-select decoder used for bus/register enables in the datapath. It turns a SEL_W-bit code into a one-hot enable vector, flags out-of-range codes, and adds a SCAN mode that steps the one-hot through a run of consecutive registers, one per cycle, for context save/restore. The block sits between the microsequencer's select fields and the register-file enable lines, using a valid/ready handshake on the command side.

## Interface
Parameters:
- SEL_W, 4, width of the select code.
- N_OUT, 2**SEL_W, width of the one-hot output.
- LIMIT, 9, number of legal codes (0..LIMIT-1); 1 ≤ LIMIT ≤ N_OUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- mode  in  1  0 = DIRECT, 1 = SCAN; sampled on accept.
- sel  in  SEL_W  start/select code; sampled on accept.
- len  in  SEL_W+1  SCAN run length, 1..LIMIT; sampled on accept; ignored in DIRECT.
- abort  in  1  cancels any command, clears the output.
- out  out  N_OUT  registered one-hot enable, or all-zero.
- out_valid  out  1  out holds a freshly decoded value this cycle.
- err  out  1  one-cycle pulse when an illegal command is rejected.
- done  out  1  one-cycle pulse on the last SCAN step, or with a DIRECT result.

## Operation
- Accept means in_valid & in_ready on a rising clk edge.
- States: IDLE and SCAN. in_ready = 1 only in IDLE and only when abort = 0.
- DIRECT, sel < LIMIT: next cycle out = 1 << sel, out_valid = 1, done = 1. out holds that value afterwards, with out_valid = 0, until the next command or abort.
- DIRECT, sel ≥ LIMIT: next cycle out = 0, err = 1, out_valid = 0, done = 0.
- SCAN, sel < LIMIT and 1 ≤ len ≤ LIMIT:
  - Enter SCAN with a step counter.
  - Emit out = 1 << idx with out_valid = 1 for len consecutive cycles, starting with idx = sel.
  - Step rule: idx = idx + 1, wrapping from LIMIT-1 to 0.
  - done = 1 with the final step. Return to IDLE on the cycle after it. out then holds the last one-hot.
- SCAN with sel ≥ LIMIT, len = 0 or len > LIMIT: rejected. Next cycle out = 0 and err = 1. Stay in IDLE.
- abort, in any state: next cycle out = 0 and out_valid, done and err are 0. State returns to IDLE and the counter clears. abort beats a simultaneous in_valid, so no accept happens.
- Arithmetic: idx is held as SEL_W bits and compared against LIMIT before any increment, so there is no overflow when LIMIT = N_OUT. The step counter is SEL_W+1 bits.

## Timing
- Reset values: out = 0, out_valid = 0, err = 0, done = 0, in_ready = 1, state IDLE. These are applied asynchronously on rst assertion. The block leaves reset on the first clk edge after rst deasserts.
- DIRECT latency: 1 cycle from accept to out/out_valid.
- SCAN latency: first step 1 cycle after accept. Last step len cycles after accept. in_ready rises on the cycle after done.
- Back-to-back DIRECT: one accept per cycle. A second command accepted on the cycle its predecessor's result appears produces its own result on the following cycle.
- rst mid-SCAN: immediate clear to reset values. No done pulse.
- No combinational path from in_valid, sel or mode to out. in_ready depends combinationally only on state and abort.

## Structure
- Package sel_dec_pkg:
  - mode_t enum: DIRECT, SCAN.
  - state_t enum: IDLE, SCAN_ST.
  - Function legal_cmd(mode, sel, len, LIMIT).
- Sub-module onehot_dec, combinational:
  - Parameters SEL_W, N_OUT, LIMIT.
  - Maps code to 1 << code, or to 0 with an in_range flag.
  - Instantiated once on the next-index path.
- Top level holds the FSM, idx, the step counter and the output registers.

## Test plan
- Reset, then DIRECT sel = 3 -> next cycle out = 0x0008, out_valid = 1, done = 1. Following cycle out = 0x0008, out_valid = 0.
- DIRECT sel = 9 with LIMIT = 9 -> out = 0x0000 and err = 1 for one cycle. in_ready stays 1.
- SCAN sel = 7, len = 4, LIMIT = 9 -> out runs 0x0080, 0x0100, 0x0001, 0x0002 on cycles 1..4. done on cycle 4. in_ready = 0 on cycles 1..4 and 1 on cycle 5.
- SCAN sel = 2, len = 6, abort on step 3 -> out = 0x0004, 0x0008, 0x0010, then 0x0000 with no done. A new DIRECT command is accepted the cycle after abort deasserts.
- LIMIT = N_OUT = 16, SCAN sel = 15, len = 16 -> wraps 0x8000, 0x0001 … 0x4000 with no X or overflow. done on step 16.
- rst asserted mid-SCAN on a non-clock edge -> all outputs 0 immediately. in_ready = 1 after release.
